// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op-class encoding, way codes, default latencies.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package md_pkg;

    // MD op class carried down the pipe from the D-stage decoder
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    // Way codes understood by the MD unit's start port
    localparam logic [2:0] WAY_NONE  = 3'd0;
    localparam logic [2:0] WAY_MULT  = 3'd1;
    localparam logic [2:0] WAY_MULTU = 3'd2;
    localparam logic [2:0] WAY_DIV   = 3'd3;
    localparam logic [2:0] WAY_DIVU  = 3'd4;

    // Busy-period lengths of the MD unit; the mirror counter is 4 bits, so keep these <= 15
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    // Raw 4-bit class field to op class; codes above mtlo are unused and mean "no MD op"
    function automatic md_op_e md_class(input logic [3:0] raw);
        md_op_e res;
        if (raw <= 4'd8) begin
            res = md_op_e'(raw);
        end else begin
            res = MD_NONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/md_busy_mirror.sv
// Cycle-exact copy of the MD unit's busy countdown plus a sticky mismatch flag.
// Latency: count loads on the start edge and is visible (nonzero) the following cycle.
// Backpressure: none; busy_any is consumed by the issue stage's stall logic.
module md_busy_mirror
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic md_busy,
    output logic busy_any,
    output logic proto_err
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    logic [3:0] cnt;
    logic       cnt_busy;

    assign cnt_busy = (cnt != 4'd0);

    // Either our own countdown or the unit itself claiming busy holds off new MD ops
    assign busy_any = cnt_busy || md_busy;

    // Countdown: reload on an issued start, otherwise run down to zero and rest there
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (start) begin
            cnt <= is_div ? DIV_CNT : MUL_CNT;
        end else if (cnt_busy) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Sticky flag whenever the unit's busy disagrees with the mirror; only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (md_busy != cnt_busy) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue/hazard control for the multiply/divide unit, with mfhi/mflo data return.
// Latency: start/way/strobes/read data are combinational from the E register (0 cycles).
// Backpressure: stall_d freezes F/D and bubbles E while an MD op would collide with a busy unit.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  d_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [2:0]  md_way,
    output logic        md_hiw,
    output logic        md_low,
    output logic [31:0] md_w1,
    output logic [31:0] md_w2,
    output logic        stall_d,
    output logic [31:0] e_md_rdata,
    output logic        e_md_rvalid,
    output logic        div0,
    output logic        proto_err
);

    md_op_e e_op;
    md_op_e d_cls;
    logic   d_is_md;
    logic   e_is_muldiv;
    logic   e_is_div;
    logic   busy_any;

    assign d_cls   = md_class(d_op);
    assign d_is_md = (d_cls != MD_NONE);

    assign e_is_div    = (e_op == MD_DIV) || (e_op == MD_DIVU);
    assign e_is_muldiv = (e_op == MD_MULT) || (e_op == MD_MULTU) || e_is_div;

    // A zero divisor never starts the unit: HI/LO stay put and no busy period follows
    assign div0     = e_is_div && (e_rt == 32'd0);
    assign md_start = e_is_muldiv && !div0 && !reset;

    assign md_hiw      = (e_op == MD_MTHI);
    assign md_low      = (e_op == MD_MTLO);
    assign e_md_rvalid = (e_op == MD_MFHI) || (e_op == MD_MFLO);
    assign md_w1       = e_rs;
    assign md_w2       = e_rt;

    // Only MD-class ops are held back; they wait out an issuing or in-flight operation
    assign stall_d = d_is_md && (md_start || busy_any);

    // Way code is presented only alongside an actual start
    always_comb begin
        md_way = WAY_NONE;
        if (md_start) begin
            case (e_op)
                MD_MULT:  md_way = WAY_MULT;
                MD_MULTU: md_way = WAY_MULTU;
                MD_DIV:   md_way = WAY_DIV;
                MD_DIVU:  md_way = WAY_DIVU;
                default:  md_way = WAY_NONE;
            endcase
        end
    end

    // mfhi/mflo read straight from the unit's HI/LO outputs in the same cycle
    always_comb begin
        e_md_rdata = 32'd0;
        case (e_op)
            MD_MFHI: e_md_rdata = md_hi;
            MD_MFLO: e_md_rdata = md_lo;
            default: e_md_rdata = 32'd0;
        endcase
    end

    // E register: advance the D op, or inject a bubble while D is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            e_op <= MD_NONE;
        end else if (stall_d) begin
            e_op <= MD_NONE;
        end else begin
            e_op <= d_cls;
        end
    end

    md_busy_mirror #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mirror (
        .clk       (clk),
        .reset     (reset),
        .start     (md_start),
        .is_div    (e_is_div),
        .md_busy   (md_busy),
        .busy_any  (busy_any),
        .proto_err (proto_err)
    );

endmodule
